// File: rtl/fps_meter_pkg.sv
// -----------------------------------------------------------------------------
// fps_meter_pkg
// Shared constants, FSM state encoding and a saturating-increment helper for
// the frame-rate meter.
//   COUNT_W   : width of the frame accumulator and of count_out
//   COUNT_MAX : saturation value of the accumulator
//   state_e   : meter FSM state (ST_IDLE / ST_RUN)
// -----------------------------------------------------------------------------
package fps_meter_pkg;

  localparam int COUNT_W = 8;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 8'd255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Adds inc to v without wrapping past COUNT_MAX.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                 input logic               inc);
    if (inc && (v != COUNT_MAX)) begin
      return v + COUNT_W'(1);
    end
    return v;
  endfunction

endpackage : fps_meter_pkg

// File: rtl/fps_meter_if.sv
// -----------------------------------------------------------------------------
// fps_meter_if
// Groups the meter's control inputs and result outputs.
//   en_in         : measurement enable
//   frame_done_in : frame-complete level; each rising edge is one frame
//   count_out     : frames counted in the last completed window (saturated)
//   update_out    : one-cycle pulse in the cycle count_out takes a new value
//   overflow_out  : last completed window saw more than COUNT_MAX frames
// Handshake: there is no back-pressure. update_out acts as a valid strobe for
// count_out/overflow_out; the consumer must capture them in that cycle or
// simply keep reading the held values, which stay stable until the next pulse.
// master = producer of en_in/frame_done_in, slave = the meter.
// -----------------------------------------------------------------------------
interface fps_meter_if;
  import fps_meter_pkg::*;

  logic               en_in;
  logic               frame_done_in;
  logic [COUNT_W-1:0] count_out;
  logic               update_out;
  logic               overflow_out;

  modport master (
    output en_in,
    output frame_done_in,
    input  count_out,
    input  update_out,
    input  overflow_out
  );

  modport slave (
    input  en_in,
    input  frame_done_in,
    output count_out,
    output update_out,
    output overflow_out
  );

endinterface : fps_meter_if

// File: rtl/fps_meter_window_tick.sv
// -----------------------------------------------------------------------------
// window_tick
// Measurement-window timer. Counts 0..CLK_FREQ-1 while enabled and wraps;
// tick is high in the terminal cycle (counter at CLK_FREQ-1).
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : count while high; counter is held at 0 while low
//   clr   : forces the counter back to 0 and suppresses tick
//   tick  : terminal-cycle indication (combinational from the counter)
// CLK_FREQ must be at least 2.
// -----------------------------------------------------------------------------
module window_tick #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule : window_tick

// File: rtl/fps_meter.sv
// -----------------------------------------------------------------------------
// fps_meter
// Counts rising edges of frame_done_in over fixed windows of CLK_FREQ clock
// cycles and publishes the count of each completed window.
//   clk_in    : system clock, rising edge
//   rst_n_in  : asynchronous active-low reset
//   bus       : fps_meter_if.slave (enable, frame input, results)
//   state_dbg : current FSM state, for observation only
// A window runs only while the FSM is in RUN with en_in high. Dropping en_in
// throws the partial window away; re-enabling starts a fresh full window.
// -----------------------------------------------------------------------------
module fps_meter
  import fps_meter_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  fps_meter_if.slave   bus,
  output state_e       state_dbg
);

  state_e             state_q, state_d;
  logic               frame_d;
  logic               frame_edge;
  logic               active;
  logic               tick;
  logic [COUNT_W-1:0] acc;
  logic               ovf_flag;
  logic [COUNT_W-1:0] count_q;
  logic               update_q;
  logic               overflow_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.en_in)  state_d = ST_RUN;
      ST_RUN:  if (!bus.en_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The cycle en_in falls is already treated as outside the window, so a
  // window can never close on a cycle whose enable is low.
  assign active     = (state_q == ST_RUN) && bus.en_in;
  assign frame_edge = bus.frame_done_in && !frame_d;

  window_tick #(
    .CLK_FREQ (CLK_FREQ)
  ) u_window_tick (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .en    (state_q == ST_RUN),
    .clr   (!bus.en_in),
    .tick  (tick)
  );

  // ---------------- datapath ----------------
  // frame_d resets high so a level already high at reset release is not
  // mistaken for a new frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_d    <= 1'b1;
      acc        <= '0;
      ovf_flag   <= 1'b0;
      count_q    <= '0;
      update_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      frame_d  <= bus.frame_done_in;
      update_q <= 1'b0;
      if (!active) begin
        acc      <= '0;
        ovf_flag <= 1'b0;
      end else if (tick) begin
        // An edge in the terminal cycle still belongs to the closing window.
        count_q    <= sat_inc(acc, frame_edge);
        overflow_q <= ovf_flag || ((acc == COUNT_MAX) && frame_edge);
        update_q   <= 1'b1;
        acc        <= '0;
        ovf_flag   <= 1'b0;
      end else if (frame_edge) begin
        if (acc == COUNT_MAX) begin
          ovf_flag <= 1'b1;
        end else begin
          acc <= acc + COUNT_W'(1);
        end
      end
    end
  end

  assign bus.count_out    = count_q;
  assign bus.update_out   = update_q;
  assign bus.overflow_out = overflow_q;
  assign state_dbg        = state_q;

endmodule : fps_meter

// File: tb/tb_fps_meter.sv
// -----------------------------------------------------------------------------
// tb_fps_meter
// Drives two meters (10-cycle and 600-cycle windows) from the same stimulus
// and compares both against a frame-counting reference model every cycle.
// -----------------------------------------------------------------------------
module tb_fps_meter;
  import fps_meter_pkg::*;

  localparam int FREQ_A = 10;
  localparam int FREQ_B = 600;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic rst_next;
  logic en_drv;
  logic fd_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fps_meter_if bus_a ();
  fps_meter_if bus_b ();
  state_e      state_a;
  state_e      state_b;

  assign bus_a.en_in         = en_drv;
  assign bus_a.frame_done_in = fd_drv;
  assign bus_b.en_in         = en_drv;
  assign bus_b.frame_done_in = fd_drv;

  fps_meter #(.CLK_FREQ(FREQ_A)) dut_a (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .bus       (bus_a),
    .state_dbg (state_a)
  );

  fps_meter #(.CLK_FREQ(FREQ_B)) dut_b (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .bus       (bus_b),
    .state_dbg (state_b)
  );

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per meter: whether it was enabled last cycle, position in the window,
  // unbounded count of frames seen this window, and the expected outputs.
  int m_freq[2] = '{FREQ_A, FREQ_B};
  bit m_run[2];
  int m_pos[2];
  int m_frames[2];
  bit m_prev[2];
  int e_count[2];
  bit e_ovf[2];
  bit e_upd[2];

  logic [COUNT_W-1:0] exp_q[$];   // window results expected from meter A

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d]    = 1'b0;
      m_pos[d]    = 0;
      m_frames[d] = 0;
      m_prev[d]   = 1'b1;
      e_count[d]  = 0;
      e_ovf[d]    = 1'b0;
      e_upd[d]    = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(input int d, input bit en, input bit fd);
    bit rise;
    rise      = fd && !m_prev[d];
    m_prev[d] = fd;
    e_upd[d]  = 1'b0;
    if (m_run[d] && en) begin
      if (rise) m_frames[d]++;
      if (m_pos[d] == m_freq[d] - 1) begin
        e_count[d]  = (m_frames[d] > 255) ? 255 : m_frames[d];
        e_ovf[d]    = (m_frames[d] > 255);
        e_upd[d]    = 1'b1;
        if (d == 0) exp_q.push_back(COUNT_W'(e_count[d]));
        m_frames[d] = 0;
        m_pos[d]    = 0;
      end else begin
        m_pos[d]++;
      end
    end else begin
      m_frames[d] = 0;
      m_pos[d]    = 0;
    end
    m_run[d] = en;
  endtask

  // ---------------- driver tasks ----------------
  // One clock: compare outputs produced by the last rising edge, then apply
  // the next inputs and advance the model past the coming rising edge.
  task automatic cycle(input bit en, input bit fd);
    @(negedge clk);
    check("a_count",    bus_a.count_out,    e_count[0]);
    check("a_update",   bus_a.update_out,   e_upd[0]);
    check("a_overflow", bus_a.overflow_out, e_ovf[0]);
    check("a_state",    state_a,            m_run[0]);
    check("b_count",    bus_b.count_out,    e_count[1]);
    check("b_update",   bus_b.update_out,   e_upd[1]);
    check("b_overflow", bus_b.overflow_out, e_ovf[1]);
    check("b_state",    state_b,            m_run[1]);
    if (bus_a.update_out === 1'b1) begin
      if (exp_q.size() == 0) check("a_sb_unexpected", 1, 0);
      else                   check("a_sb_count", bus_a.count_out, exp_q.pop_front());
    end
    rst_n  = rst_next;
    en_drv = en;
    fd_drv = fd;
    if (rst_n) begin
      model_step(0, en, fd);
      model_step(1, en, fd);
    end
  endtask

  task automatic run_cycles(input int n, input bit en, input logic [63:0] bits);
    for (int k = 0; k < n; k++) cycle(en, bits[k]);
  endtask

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic async_reset();
    #2;
    rst_n    = 1'b0;
    rst_next = 1'b0;
    model_reset();
    #1;
    check("rst_a_count",    bus_a.count_out,    0);
    check("rst_a_update",   bus_a.update_out,   0);
    check("rst_a_overflow", bus_a.overflow_out, 0);
    check("rst_b_count",    bus_b.count_out,    0);
    check("rst_b_update",   bus_b.update_out,   0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    rst_n    = 1'b0;
    rst_next = 1'b0;
    en_drv   = 1'b0;
    fd_drv   = 1'b0;
    model_reset();

    // Reset state.
    run_cycles(2, 1'b0, 64'h0);
    rst_next = 1'b1;

    // Three frames in the first window.
    run_cycles(12, 1'b1, 64'h54);
    check("w1_count", bus_a.count_out, 3);
    check("w1_update", bus_a.update_out, 1);
    check("w1_overflow", bus_a.overflow_out, 0);

    // Two frames plus one exactly on the terminal cycle.
    run_cycles(10, 1'b1, 64'h10a);
    check("term_edge_count", bus_a.count_out, 3);
    // The terminal edge must not leak into the following window.
    run_cycles(10, 1'b1, 64'h0);
    check("term_next_count", bus_a.count_out, 0);
    check("term_next_update", bus_a.update_out, 1);

    // Five frames, then a window abandoned by dropping enable.
    run_cycles(10, 1'b1, 64'h155);
    check("w5_count", bus_a.count_out, 5);
    run_cycles(4, 1'b1, 64'h5);
    run_cycles(6, 1'b0, 64'h0);
    check("drop_hold_count", bus_a.count_out, 5);
    check("drop_no_update", bus_a.update_out, 0);
    run_cycles(1, 1'b1, 64'h0);
    run_cycles(10, 1'b1, 64'h0);
    check("reen_no_early_update", bus_a.update_out, 0);
    run_cycles(1, 1'b1, 64'h0);
    check("reen_update", bus_a.update_out, 1);
    check("reen_count", bus_a.count_out, 0);

    // Reset in the middle of a window after a non-zero result.
    run_cycles(10, 1'b1, 64'h155);
    check("pre_reset_count", bus_a.count_out, 5);
    run_cycles(3, 1'b1, 64'h1);
    async_reset();

    // Frame input held high across reset release: not a frame.
    run_cycles(2, 1'b0, 64'hffff_ffff_ffff_ffff);
    rst_next = 1'b1;
    run_cycles(12, 1'b1, 64'hffff_ffff_ffff_ffff);
    check("held_high_count", bus_a.count_out, 0);
    check("held_high_update", bus_a.update_out, 1);

    // Long window: toggle every cycle until two full windows closed on B.
    seen = 0;
    for (int k = 0; k < 2000 && seen < 2; k++) begin
      cycle(1'b1, !fd_drv);
      if (e_upd[1]) seen++;
    end
    check("b_terminals_seen", seen, 2);
    cycle(1'b1, 1'b0);
    check("b_sat_count", bus_b.count_out, 255);
    check("b_sat_overflow", bus_b.overflow_out, 1);
    check("b_sat_update", bus_b.update_out, 1);
    for (int k = 1; k < FREQ_B; k++) cycle(1'b1, (k == 1 || k == 3 || k == 5 || k == 7));
    cycle(1'b1, 1'b0);
    check("b_after_count", bus_b.count_out, 4);
    check("b_after_overflow", bus_b.overflow_out, 0);

    // Randomized segments: enable on/off, dense/random/sparse frames, resets.
    for (int seg = 0; seg < 14; seg++) begin
      int len;
      int mode;
      bit en;
      len  = $urandom_range(5, 700);
      mode = $urandom_range(0, 2);
      en   = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 7) == 0) begin
        async_reset();
        run_cycles(2, 1'b0, 64'h0);
        rst_next = 1'b1;
      end
      for (int k = 0; k < len; k++) begin
        bit fd;
        case (mode)
          0:       fd = !fd_drv;
          1:       fd = 1'($urandom_range(0, 1));
          default: fd = ($urandom_range(0, 7) == 0);
        endcase
        cycle(en, fd);
      end
    end

    run_cycles(2, 1'b0, 64'h0);
    check("a_sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_fps_meter

// File: doc/fps_meter.md
FPS_METER -- requirements
Module: fps_meter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning clk_in cycles per measurement window (1 s).
REQ-002 SHALL have port clk_in  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n_in  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port en_in  input  1  measurement enable, synchronous to clk_in.
REQ-005 SHALL have port frame_done_in  input  1  frame-complete indication, synchronous to clk_in; each rising edge counts one frame.
REQ-006 SHALL have port count_out  output  8  frames counted in last completed window, saturated at 255; feeds segment display count input.
REQ-007 SHALL have port update_out  output  1  one-cycle pulse when count_out is reloaded.
REQ-008 SHALL have port overflow_out  output  1  high when last completed window saw more than 255 frames.

Function
REQ-009 SHALL register frame_done_in into frame_d; edge = frame_done_in AND NOT frame_d.
REQ-010 SHALL implement states IDLE and RUN: IDLE->RUN when en_in=1; RUN->IDLE when en_in=0.
REQ-011 In IDLE, SHALL hold window counter and accumulator at 0 and hold count_out/overflow_out unchanged; update_out=0.
REQ-012 In RUN, window counter SHALL count 0..CLK_FREQ-1 and wrap to 0; terminal cycle = counter at CLK_FREQ-1.
REQ-013 In RUN, accumulator (8 bit) SHALL increment by 1 per edge, saturating at 255; an edge arriving at 255 SHALL set an overflow flag for the window.
REQ-014 On terminal cycle, SHALL load count_out = saturate(acc + edge), overflow_out = flag OR (acc=255 AND edge), then clear acc and flag; edge on terminal cycle belongs to the closing window.
REQ-015 update_out SHALL be high exactly the cycle after the terminal cycle (same cycle count_out shows the new value); latency terminal->count_out = 1 cycle.
REQ-016 Edges while in IDLE SHALL be ignored; frame_d SHALL still track frame_done_in.
REQ-017 en_in falling mid-window SHALL discard the partial window (no update, acc cleared); the next RUN entry SHALL start a full window at counter 0.
REQ-018 Window counter width SHALL be clog2(CLK_FREQ); CLK_FREQ SHALL be >= 2.

Reset
REQ-019 On rst_n_in=0: state=IDLE, window counter=0, acc=0, flag=0, count_out=0, update_out=0, overflow_out=0, frame_d=1 (a high input at reset release does not count).
REQ-020 Reset assertion mid-window SHALL abandon the window immediately; no update pulse is produced.

Structure
REQ-021 Shared package SHALL hold COUNT_W=8, COUNT_MAX=255 and the state encoding (IDLE, RUN).
REQ-022 SHALL contain one sub-module, window_tick, generating the terminal-cycle pulse from CLK_FREQ with enable/clear input.
REQ-023 All outputs SHALL be driven directly from registers.

Verification (CLK_FREQ=10)
REQ-024 Reset, en_in=1, 3 single-cycle frame_done pulses in window -> after 10 cycles count_out=3, update_out one pulse, overflow_out=0.
REQ-025 frame_done_in toggling every cycle for 300 windows-worth edges with CLK_FREQ=600 -> count_out=255, overflow_out=1; next window with 4 edges -> count_out=4, overflow_out=0.
REQ-026 Edge exactly on terminal cycle with 2 earlier edges -> count_out=3; next window's count excludes it.
REQ-027 en_in dropped at cycle 5 after 2 edges -> no update_out, count_out holds previous value; re-enable -> first update after 10 full cycles.
REQ-028 frame_done_in held high across reset release, en_in=1, no further edges -> count_out=0 after first window.
REQ-029 rst_n_in pulsed low mid-window with count_out=7 -> count_out=0, update_out=0 immediately, asynchronously.
